div_seq_nonrestoring: RTL

- Iterative radix-2 non-restoring divider, signed or unsigned. It is the inverse-operation counterpart to the team's combinational Booth multiplier.
- Produces quotient and remainder of Bits-wide operands, one quotient bit per cycle.
- Sits beside the multiplier in the integer execute path.
- Valid/ready handshake on both input and output.

---
 rtl/div_seq_nonrestoring_pkg.sv | 24 ++
 rtl/div_seq_nonrestoring_if.sv | 25 ++
 rtl/div_seq_nonrestoring_nr_step.sv | 22 ++
 rtl/div_seq_nonrestoring.sv | 127 ++++++++++++
 4 files changed

// File: rtl/div_seq_nonrestoring_pkg.sv
// rtl/div_seq_nonrestoring_pkg.sv - shared state encoding and result patterns for the divider
package div_seq_nonrestoring_pkg;

  localparam int MaxBits = 128;

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  function automatic logic [MaxBits-1:0] ones_pat(input int w);
    logic [MaxBits-1:0] v;
    v = '0;
    for (int i = 0; i < MaxBits; i++)
      if (i < w) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [MaxBits-1:0] min_pat(input int w);
    logic [MaxBits-1:0] v;
    v = '0;
    for (int i = 0; i < MaxBits; i++)
      if (i == w - 1) v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/div_seq_nonrestoring_if.sv
// rtl/div_seq_nonrestoring_if.sv - request/result handshake bundle of the divider
interface div_seq_nonrestoring_if #(parameter int Bits = 64);

  logic            in_valid;
  logic            in_ready;
  logic [Bits-1:0] a;
  logic [Bits-1:0] b;
  logic            is_signed;
  logic            out_valid;
  logic            out_ready;
  logic [Bits-1:0] quot;
  logic [Bits-1:0] rem;
  logic            div_zero;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, quot, rem, div_zero
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, quot, rem, div_zero
  );

endinterface

// File: rtl/div_seq_nonrestoring_nr_step.sv
// rtl/div_seq_nonrestoring_nr_step.sv - one combinational non-restoring shift/add-or-subtract step
module div_nr_step #(
  parameter int Bits = 64
) (
  input  logic [Bits:0]   r_in,
  input  logic [Bits-1:0] q_in,
  input  logic [Bits-1:0] d,
  output logic [Bits:0]   r_out,
  output logic [Bits-1:0] q_out
);

  logic [Bits:0] r_sh;

  // Add/subtract is chosen from the sign before the shift; dropping r_in[Bits]
  // in the shift is safe because the result always fits Bits+1 signed bits.
  always_comb begin
    r_sh  = {r_in[Bits-1:0], q_in[Bits-1]};
    r_out = r_in[Bits] ? (r_sh + {1'b0, d}) : (r_sh - {1'b0, d});
    q_out = {q_in[Bits-2:0], ~r_out[Bits]};
  end

endmodule

// File: rtl/div_seq_nonrestoring.sv
// rtl/div_seq_nonrestoring.sv - iterative radix-2 signed/unsigned non-restoring divider
module div_seq_nonrestoring
  import div_seq_nonrestoring_pkg::*;
#(
  parameter int Bits = 64,
  parameter int CntW = $clog2(Bits + 1)
) (
  input logic                  clk,
  input logic                  reset_n,
  div_seq_nonrestoring_if.slave bus
);

  localparam logic [Bits-1:0] Ones = Bits'(ones_pat(Bits));
  localparam logic [Bits-1:0] MinV = Bits'(min_pat(Bits));

  state_t          state;
  logic [Bits-1:0] a_q, b_q;
  logic            signed_q;
  logic [Bits:0]   r;
  logic [Bits-1:0] q, mb;
  logic [CntW-1:0] cnt;
  logic            sign_q, sign_r;
  logic            in_ready_r, out_valid_r, div_zero_r;
  logic [Bits-1:0] quot_r, rem_r;

  logic            a_neg, b_neg;
  logic [Bits-1:0] mag_a, mag_b, rem_mag;
  logic [Bits:0]   r_nx;
  logic [Bits-1:0] q_nx;

  always_comb begin
    a_neg   = signed_q & a_q[Bits-1];
    b_neg   = signed_q & b_q[Bits-1];
    mag_a   = a_neg ? -a_q : a_q;
    mag_b   = b_neg ? -b_q : b_q;
    rem_mag = r[Bits] ? (r[Bits-1:0] + mb) : r[Bits-1:0];
  end

  div_nr_step #(.Bits(Bits)) u_step (
    .r_in  (r),
    .q_in  (q),
    .d     (mb),
    .r_out (r_nx),
    .q_out (q_nx)
  );

  // Special cases preload Q/R with unsigned final values and still pass through
  // FIX, so every result leaves through one output path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      quot_r      <= '0;
      rem_r       <= '0;
      div_zero_r  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      r           <= '0;
      q           <= '0;
      mb          <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid && in_ready_r) begin
          a_q        <= bus.a;
          b_q        <= bus.b;
          signed_q   <= bus.is_signed;
          div_zero_r <= 1'b0;
          in_ready_r <= 1'b0;
          state      <= PREP;
        end
        PREP: begin
          mb  <= mag_b;
          r   <= '0;
          cnt <= CntW'(Bits);
          if (b_q == '0) begin
            q          <= Ones;
            r          <= {1'b0, a_q};
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            div_zero_r <= 1'b1;
            state      <= FIX;
          end else if (signed_q && a_q == MinV && b_q == Ones) begin
            q      <= MinV;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            state  <= FIX;
          end else begin
            q      <= mag_a;
            sign_q <= a_neg ^ b_neg;
            sign_r <= a_neg;
            state  <= ITER;
          end
        end
        ITER: begin
          r   <= r_nx;
          q   <= q_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CntW'(1)) state <= FIX;
        end
        FIX: begin
          quot_r      <= sign_q ? -q : q;
          rem_r       <= sign_r ? -rem_mag : rem_mag;
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.quot      = quot_r;
  assign bus.rem       = rem_r;
  assign bus.div_zero  = div_zero_r;

endmodule
